flappy_controller: RTL and testbench

FLAPPY_CONTROLLER -- requirements
Module: flappy_controller

---
 rtl/flappy_pkg.sv | 24 ++
 rtl/flappy_controller_lfsr16.sv | 24 ++
 rtl/flappy_controller.sv | 155 +++++++++++++++
 tb/tb_flappy_controller.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared encodings for the flappy game controller: scenes, key codes and the
// layout of one 24-bit pipe record on the gaps bus.
package flappy_pkg;

    typedef enum logic [1:0] {
        SCENE_SPLASH   = 2'd0,
        SCENE_PLAYING  = 2'd1,
        SCENE_GAMEOVER = 2'd2
    } scene_t;

    localparam logic [7:0] KEY_SPACE   = 8'd32;
    localparam logic [7:0] KEY_RESTART = 8'd114;
    localparam logic [7:0] KEY_QUIT    = 8'd120;

    // Pipe record is {position, max_bnd, min_bnd}, one byte each.
    localparam int GAP_FIELD_W = 8;
    localparam int GAP_REC_W   = 24;
    localparam int GAP_MIN_OFS = 0;
    localparam int GAP_MAX_OFS = 8;
    localparam int GAP_POS_OFS = 16;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/flappy_controller_lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11) used to randomise pipe gaps on wrap.
module lfsr16
    import flappy_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic        clk,
    input  logic        srst,
    output logic [15:0] value
);

    logic [15:0] lfsr_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            lfsr_reg <= SEED;
        end else begin
            lfsr_reg <= {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign value = lfsr_reg;

endmodule

// File: rtl/flappy_controller.sv
// Flappy-bird game controller: scene FSM, bird physics, scrolling pipes with
// randomised gaps, collision detection and scoring.
module flappy_controller
    import flappy_pkg::*;
#(
    parameter int NUM_PIPES     = 3,
    parameter int HEIGHT        = 40,
    parameter int WIDTH         = 80,
    parameter int GAP           = 10,
    parameter int BIRD_COL      = 4,
    parameter int FLAP_HOLD     = 5,
    parameter int FALL_PERIOD   = 4,
    parameter int SCROLL_PERIOD = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                inp,
    output logic [1:0]                scene,
    output logic [8:0]                bird,
    output logic [24*NUM_PIPES-1:0]   gaps,
    output logic [15:0]               score
);

    localparam logic [7:0]  ALT_INIT    = 8'(HEIGHT / 2);
    localparam logic [7:0]  ALT_TOP     = 8'(HEIGHT - 1);
    localparam logic [7:0]  MIN_INIT    = 8'(HEIGHT / 2 - GAP / 2);
    localparam logic [7:0]  GAP_W       = 8'(GAP);
    localparam logic [7:0]  POS_WRAP    = 8'(WIDTH - 1);
    localparam logic [7:0]  BIRD_POS    = 8'(BIRD_COL);
    localparam logic [7:0]  FLAP_LOAD   = 8'(FLAP_HOLD);
    localparam logic [15:0] FALL_LAST   = 16'(FALL_PERIOD - 1);
    localparam logic [15:0] SCROLL_LAST = 16'(SCROLL_PERIOD - 1);
    localparam logic [15:0] BND_SPAN    = 16'(HEIGHT - GAP - 1);

    scene_t               scene_reg;
    logic [7:0]           alt_reg;
    logic [7:0]           flap_cnt_reg;
    logic [15:0]          fall_cnt_reg;
    logic [15:0]          scroll_cnt_reg;
    logic [15:0]          score_reg;
    logic [15:0]          lfsr_value;
    logic [NUM_PIPES-1:0] hit;
    logic [NUM_PIPES-1:0] pass;
    logic                 flapping;
    logic                 playing;
    logic                 restart;
    logic                 collision;
    logic                 advance;
    logic                 shift_tick;
    logic [7:0]           wrap_min;

    lfsr16 u_lfsr (
        .clk   (clk),
        .srst  (rst),
        .value (lfsr_value)
    );

    assign flapping   = (flap_cnt_reg != 8'd0);
    assign playing    = (scene_reg == SCENE_PLAYING);
    assign restart    = (scene_reg == SCENE_GAMEOVER) && (inp == KEY_RESTART);
    assign shift_tick = (scroll_cnt_reg == SCROLL_LAST);
    assign collision  = playing && ((|hit) || (alt_reg == 8'd0));
    // World state only moves on a clean PLAYING cycle; the quitting or
    // colliding cycle freezes everything so GAMEOVER shows the final frame.
    assign advance    = playing && !collision && (inp != KEY_QUIT);
    assign wrap_min   = 8'(16'd1 + (lfsr_value % BND_SPAN));

    for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
        localparam logic [7:0] POS_INIT = 8'(WIDTH / 2 + gi * (WIDTH / NUM_PIPES));
        localparam int         BASE     = GAP_REC_W * (NUM_PIPES - gi - 1);

        logic [7:0] pos_reg;
        logic [7:0] min_reg;
        logic [7:0] max_reg;

        assign hit[gi]  = (pos_reg == BIRD_POS) &&
                          ((alt_reg <= min_reg) || (alt_reg >= max_reg));
        assign pass[gi] = advance && shift_tick && (pos_reg == BIRD_POS);

        always_ff @(posedge clk) begin
            if (rst || restart) begin
                pos_reg <= POS_INIT;
                min_reg <= MIN_INIT;
                max_reg <= MIN_INIT + GAP_W;
            end else if (advance && shift_tick) begin
                if (pos_reg == 8'd0) begin
                    pos_reg <= POS_WRAP;
                    min_reg <= wrap_min;
                    max_reg <= wrap_min + GAP_W;
                end else begin
                    pos_reg <= pos_reg - 8'd1;
                end
            end
        end

        assign gaps[BASE + GAP_POS_OFS +: GAP_FIELD_W] = pos_reg;
        assign gaps[BASE + GAP_MAX_OFS +: GAP_FIELD_W] = max_reg;
        assign gaps[BASE + GAP_MIN_OFS +: GAP_FIELD_W] = min_reg;
    end

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            scene_reg      <= SCENE_SPLASH;
            alt_reg        <= ALT_INIT;
            flap_cnt_reg   <= 8'd0;
            fall_cnt_reg   <= 16'd0;
            scroll_cnt_reg <= 16'd0;
            score_reg      <= 16'd0;
        end else begin
            case (scene_reg)
                SCENE_SPLASH: begin
                    if (inp != 8'd0) begin
                        scene_reg <= SCENE_PLAYING;
                    end
                end
                SCENE_PLAYING: begin
                    if (!advance) begin
                        scene_reg <= SCENE_GAMEOVER;
                    end else begin
                        if (inp == KEY_SPACE) begin
                            flap_cnt_reg <= FLAP_LOAD;
                        end else if (flapping) begin
                            flap_cnt_reg <= flap_cnt_reg - 8'd1;
                        end

                        if (flapping) begin
                            fall_cnt_reg <= 16'd0;
                            if (alt_reg < ALT_TOP) begin
                                alt_reg <= alt_reg + 8'd1;
                            end
                        end else if (fall_cnt_reg >= FALL_LAST) begin
                            fall_cnt_reg <= 16'd0;
                            alt_reg      <= alt_reg - 8'd1;
                        end else begin
                            fall_cnt_reg <= fall_cnt_reg + 16'd1;
                        end

                        scroll_cnt_reg <= shift_tick ? 16'd0 : scroll_cnt_reg + 16'd1;

                        if ((|pass) && (score_reg != 16'hFFFF)) begin
                            score_reg <= score_reg + 16'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign scene = scene_reg;
    assign bird  = {alt_reg, flapping};
    assign score = score_reg;

endmodule

// File: tb/tb_flappy_controller.sv
// Self-checking bench for flappy_controller: table-driven vectors plus
// hand-written game sequences, all compared through a scoreboard queue.
module tb_flappy_controller;
    import flappy_pkg::*;

    localparam int NP = 3;
    localparam int DC = -1;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        inp;
    logic [1:0]        scene;
    logic [8:0]        bird;
    logic [24*NP-1:0]  gaps;
    logic [15:0]       score;
    logic [1:0]        f_scene;
    logic [8:0]        f_bird;
    logic [24*NP-1:0]  f_gaps;
    logic [15:0]       f_score;

    typedef struct {
        logic [7:0] inp;
        int scene; int alt; int flap; int score; int pos0;
    } vec_t;

    typedef struct {
        string tag;
        int scene; int alt; int flap; int score; int pos0;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    flappy_controller #(.NUM_PIPES(NP)) dut (
        .clk(clk), .rst(rst), .inp(inp),
        .scene(scene), .bird(bird), .gaps(gaps), .score(score)
    );

    flappy_controller #(.NUM_PIPES(NP), .FALL_PERIOD(1)) dut_fast (
        .clk(clk), .rst(rst), .inp(inp),
        .scene(f_scene), .bird(f_bird), .gaps(f_gaps), .score(f_score)
    );

    function automatic int pipe_field(input logic [24*NP-1:0] g, input int i, input int ofs);
        logic [23:0] rec;
        rec = g[24*(NP-i)-1 -: 24];
        return int'(rec[ofs +: 8]);
    endfunction

    function automatic vec_t mk(input logic [7:0] k, input int sc, input int al,
                                input int fl, input int so, input int p0);
        vec_t v;
        v = '{k, sc, al, fl, so, p0};
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic compare_pop();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
            return;
        end
        e = sb.pop_front();
        if (e.scene != DC) chk({e.tag, ".scene"}, int'(scene), e.scene);
        if (e.alt   != DC) chk({e.tag, ".alt"},   int'(bird[8:1]), e.alt);
        if (e.flap  != DC) chk({e.tag, ".flap"},  int'(bird[0]), e.flap);
        if (e.score != DC) chk({e.tag, ".score"}, int'(score), e.score);
        if (e.pos0  != DC) chk({e.tag, ".pos0"},  pipe_field(gaps, 0, 16), e.pos0);
    endtask

    task automatic drive(input string tag, input vec_t v);
        exp_t e;
        inp = v.inp;
        e = '{tag, v.scene, v.alt, v.flap, v.score, v.pos0};
        sb.push_back(e);
        @(posedge clk);
        #1;
        $display("txn %s inp=%0d scene=%0d alt=%0d flap=%0d score=%0d pos0=%0d",
                 tag, v.inp, scene, bird[8:1], bird[0], score, pipe_field(gaps, 0, 16));
        compare_pop();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".scene"}, int'(scene), 0);
        chk({tag, ".alt"},   int'(bird[8:1]), 20);
        chk({tag, ".flap"},  int'(bird[0]), 0);
        chk({tag, ".score"}, int'(score), 0);
        for (int i = 0; i < NP; i++) begin
            chk($sformatf("%s.pipe%0d.pos", tag, i), pipe_field(gaps, i, 16), 40 + i * 26);
            chk($sformatf("%s.pipe%0d.max", tag, i), pipe_field(gaps, i, 8), 25);
            chk($sformatf("%s.pipe%0d.min", tag, i), pipe_field(gaps, i, 0), 15);
        end
    endtask

    task automatic do_reset(input string tag, input logic [7:0] k);
        rst = 1'b1;
        inp = k;
        @(posedge clk);
        #1;
        rst = 1'b0;
        inp = 8'd0;
        $display("txn %s rst=1 inp=%0d scene=%0d alt=%0d score=%0d", tag, k, scene, bird[8:1], score);
        check_reset_state(tag);
    endtask

    // Autopilot flaps whenever the bird sinks to 17, keeping it inside the
    // initial 15..25 gaps; expected score and pipe0 position follow from time.
    task automatic play(input string tag, input int n);
        for (int k = 1; k <= n; k++) begin
            logic [7:0] key;
            int s, p0, sc, mn, mx;
            key = (int'(bird[8:1]) <= 17 && !bird[0]) ? KEY_SPACE : 8'd0;
            s   = k / 2;
            p0  = (s <= 40) ? 40 - s : 79 - (s - 41);
            sc  = int'(k >= 74) + int'(k >= 126) + int'(k >= 178);
            drive($sformatf("%s%0d", tag, k), mk(key, 1, DC, DC, sc, p0));
            if (k == 82) begin
                mn = pipe_field(gaps, 0, 0);
                mx = pipe_field(gaps, 0, 8);
                chk({tag, ".wrap_span"}, mx - mn, 10);
                chk({tag, ".wrap_min_ge1"}, int'(mn >= 1), 1);
                chk({tag, ".wrap_max_le39"}, int'(mx <= 39), 1);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        inp = 8'd0;

        for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 0, 20, 0, 0, 40));
        vecs.push_back(mk(97,  1, 20, 0, 0, 40));
        vecs.push_back(mk(32,  1, 20, 1, 0, 40));
        vecs.push_back(mk(0,   1, 21, 1, 0, 39));
        vecs.push_back(mk(0,   1, 22, 1, 0, 39));
        vecs.push_back(mk(0,   1, 23, 1, 0, 38));
        vecs.push_back(mk(0,   1, 24, 1, 0, 38));
        vecs.push_back(mk(0,   1, 25, 0, 0, 37));
        vecs.push_back(mk(0,   1, 25, 0, 0, 37));
        vecs.push_back(mk(0,   1, 25, 0, 0, 36));
        vecs.push_back(mk(0,   1, 25, 0, 0, 36));
        vecs.push_back(mk(0,   1, 24, 0, 0, 35));
        vecs.push_back(mk(32,  1, 24, 1, 0, 35));
        vecs.push_back(mk(0,   1, 25, 1, 0, 34));
        vecs.push_back(mk(32,  1, 26, 1, 0, 34));
        vecs.push_back(mk(0,   1, 27, 1, 0, 33));
        vecs.push_back(mk(0,   1, 28, 1, 0, 33));
        vecs.push_back(mk(0,   1, 29, 1, 0, 32));
        vecs.push_back(mk(0,   1, 30, 1, 0, 32));
        vecs.push_back(mk(0,   1, 31, 0, 0, 31));
        vecs.push_back(mk(120, 2, 31, 0, 0, 31));
        vecs.push_back(mk(32,  2, 31, 0, 0, 31));
        vecs.push_back(mk(97,  2, 31, 0, 0, 31));
        vecs.push_back(mk(0,   2, 31, 0, 0, 31));
        vecs.push_back(mk(114, 0, 20, 0, 0, 40));
        vecs.push_back(mk(0,   0, 20, 0, 0, 40));

        do_reset("reset", 8'd0);
        foreach (vecs[i]) drive($sformatf("vec%0d", i), vecs[i]);

        // Holding space saturates altitude at HEIGHT-1.
        drive("sat_start", mk(97, 1, 20, 0, 0, 40));
        for (int k = 1; k <= 25; k++) begin
            drive($sformatf("sat%0d", k), mk(32, 1, (19 + k < 39) ? 19 + k : 39, 1, 0, 40 - k / 2));
        end
        drive("sat_quit", mk(120, 2, 39, 1, 0, 28));

        // Free fall into pipe0 at the bird column; the fast-fall twin hits the floor.
        do_reset("fall_reset", 8'd0);
        drive("fall_start", mk(97, 1, 20, 0, 0, 40));
        for (int k = 1; k <= 72; k++) begin
            drive($sformatf("fall%0d", k), mk(0, 1, 20 - k / 4, 0, 0, 40 - k / 2));
            if (k == 20) begin
                chk("fast.alt_floor", int'(f_bird[8:1]), 0);
                chk("fast.flap", int'(f_bird[0]), 0);
                chk("fast.scene_still_playing", int'(f_scene), 1);
                chk("fast.pos0", pipe_field(f_gaps, 0, 16), 30);
            end
            if (k == 21) begin
                chk("fast.scene_gameover", int'(f_scene), 2);
                chk("fast.score", int'(f_score), 0);
            end
        end
        drive("fall_hit", mk(0, 2, 2, 0, 0, 4));
        drive("fall_frozen", mk(0, 2, 2, 0, 0, 4));

        // Flap through three pipes, quit, then restart from GAMEOVER.
        do_reset("play_reset", 8'd0);
        drive("play_start", mk(97, 1, 20, 0, 0, DC));
        play("playA", 180);
        drive("playA_quit", mk(120, 2, DC, DC, 3, DC));
        drive("playA_frozen", mk(0, 2, DC, DC, 3, DC));
        drive("playA_restart", mk(114, 0, 20, 0, 0, 40));
        check_reset_state("restart");

        // Same run again, then rst with space held mid-game.
        do_reset("play2_reset", 8'd0);
        drive("play2_start", mk(97, 1, 20, 0, 0, DC));
        play("playB", 180);
        chk("playB.score_before_rst", int'(score), 3);
        do_reset("rst_mid_play", KEY_SPACE);
        drive("post_rst_idle", mk(0, 0, 20, 0, 0, 40));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
